shift_engine: RTL and testbench



---
 rtl/shift_engine_pkg.sv | 17 +
 rtl/shift_engine_shift_step.sv | 42 ++++
 rtl/shift_engine.sv | 135 +++++++++++++
 tb/tb_shift_engine.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_engine_pkg.sv
// Shared constants for shift_engine: mode and direction encodings, FSM states.
package shift_engine_pkg;

  localparam logic [1:0] MODE_LOGICAL = 2'b00;
  localparam logic [1:0] MODE_ARITH   = 2'b01;
  localparam logic [1:0] MODE_ROTATE  = 2'b10;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_engine_shift_step.sv
// shift_step: combinational single-bit shift of a WIDTH-bit word.
// Right shifts expose q[0], left shifts expose q[WIDTH-1]; the fill bit
// depends on mode (arithmetic only matters for right shifts, the reserved
// mode code behaves as logical).
module shift_step
  import shift_engine_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] next_q,
  output logic             out_bit
);

  logic fill_s;

  // Select the fill bit and the shifted-out bit for one step.
  always_comb begin
    fill_s  = 1'b0;
    next_q  = q;
    out_bit = 1'b0;
    if (dir == DIR_RIGHT) begin
      out_bit = q[0];
      case (mode)
        MODE_ARITH:  fill_s = q[WIDTH-1];
        MODE_ROTATE: fill_s = q[0];
        default:     fill_s = 1'b0;
      endcase
      next_q = {fill_s, q[WIDTH-1:1]};
    end else begin
      out_bit = q[WIDTH-1];
      case (mode)
        MODE_ROTATE: fill_s = q[WIDTH-1];
        default:     fill_s = 1'b0;
      endcase
      next_q = {q[WIDTH-2:0], fill_s};
    end
  end

endmodule

// File: rtl/shift_engine.sv
// shift_engine: parallel-load register shifted left/right one bit per clock
// in logical, arithmetic or rotate mode, sequenced by a start/busy/done
// handshake. Defining SHIFT_ENGINE_ABORT_EN adds an abort input that
// cancels an in-flight shift, keeping the partial result.
module shift_engine
  import shift_engine_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] amount,
`ifdef SHIFT_ENGINE_ABORT_EN
  input  logic             abort,
`endif
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             ser_q, ser_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [1:0]       mode_q, mode_d;

  logic [WIDTH-1:0] step_q_s;
  logic             step_bit_s;
  logic             abort_s;

`ifdef SHIFT_ENGINE_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  shift_step #(.WIDTH(WIDTH)) u_step (
    .q       (q_q),
    .dir     (dir_q),
    .mode    (mode_q),
    .next_q  (step_q_s),
    .out_bit (step_bit_s)
  );

  // Next-state logic: IDLE accepts load (priority) or start, SHIFT steps once per clock.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    ser_d   = ser_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          q_d     = load_val;
          state_d = IDLE;
        end else if (start) begin
          dir_d  = dir;
          mode_d = mode;
          cnt_d  = amount;
          if (amount == AMT_W'(0)) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (abort_s) begin
          cnt_d   = AMT_W'(0);
          state_d = IDLE;
        end else begin
          q_d   = step_q_s;
          ser_d = step_bit_s;
          cnt_d = cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      q_q     <= '0;
      ser_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      dir_q   <= DIR_RIGHT;
      mode_q  <= MODE_LOGICAL;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      ser_q   <= ser_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
    end
  end

  assign q       = q_q;
  assign ser_out = ser_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_shift_engine.sv
// Scoreboard bench for shift_engine (WIDTH=8). The stimulus process pushes
// the expected final word, last shifted-out bit and busy length for every
// operation that should complete; a monitor pops and compares on each done.
// With SHIFT_ENGINE_ABORT_EN defined the abort path is also exercised.
module tb_shift_engine;

  localparam int W  = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          load;
  logic [W-1:0]  load_val;
  logic          start;
  logic          dir;
  logic [1:0]    mode;
  logic [AW-1:0] amount;
`ifdef SHIFT_ENGINE_ABORT_EN
  logic          abort;
`endif
  logic [W-1:0]  q;
  logic          ser_out;
  logic          busy;
  logic          done;

  typedef struct {
    logic [7:0] q;
    logic       ser;
    int         steps;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] m_q;
  logic       m_ser;

  shift_engine #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .dir      (dir),
    .mode     (mode),
    .amount   (amount),
`ifdef SHIFT_ENGINE_ABORT_EN
    .abort    (abort),
`endif
    .q        (q),
    .ser_out  (ser_out),
    .busy     (busy),
    .done     (done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Closed-form result of n single-bit steps: {final word, last bit out}.
  function automatic logic [8:0] ref_op(input logic [7:0] v, input logic s,
                                        input logic d, input logic [1:0] m, input int n);
    logic [15:0]       w;
    logic signed [7:0] sv;
    logic [7:0]        res;
    logic              so;
    int                r;
    if (n == 0) return {v, s};
    r = n % 8;
    w = {v, v};
    if (m == 2'b10) begin
      if (!d) begin
        w   = w >> r;
        res = w[7:0];
        so  = v[(n - 1) % 8];
      end else begin
        w   = w << r;
        res = w[15:8];
        so  = v[7 - ((n - 1) % 8)];
      end
    end else if (!d && m == 2'b01) begin
      sv  = v;
      sv  = sv >>> n;
      res = sv;
      so  = v[(n - 1 < 8) ? (n - 1) : 7];
    end else if (!d) begin
      res = (n >= 8) ? 8'h00 : (v >> n);
      so  = (n <= 8) ? v[n - 1] : 1'b0;
    end else begin
      res = (n >= 8) ? 8'h00 : (v << n);
      so  = (n <= 8) ? v[8 - n] : 1'b0;
    end
    return {res, so};
  endfunction

  task automatic do_load(input logic [7:0] v);
    load     = 1'b1;
    load_val = v;
    tick();
    load     = 1'b0;
    m_q      = v;
  endtask

  task automatic issue_start(input logic d, input logic [1:0] m, input logic [3:0] amt, input bit push);
    logic [8:0] r;
    exp_t       e;
    r = ref_op(m_q, m_ser, d, m, int'(amt));
    if (push) begin
      e.q     = r[8:1];
      e.ser   = r[0];
      e.steps = int'(amt);
      sb.push_back(e);
    end
    m_q    = r[8:1];
    m_ser  = r[0];
    dir    = d;
    mode   = m;
    amount = amt;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_done(input bit noise);
    int k;
    k = 0;
    while (!done && k < 40) begin
      if (noise) begin
        load     = 1'($urandom_range(1));
        start    = 1'($urandom_range(1));
        load_val = 8'($urandom);
        dir      = 1'($urandom_range(1));
        mode     = 2'($urandom_range(3));
        amount   = 4'($urandom_range(15));
      end
      tick();
      k++;
    end
    if (k >= 40) chk("done_timeout", 32'(done), 32'd1);
    tick();
    load  = 1'b0;
    start = 1'b0;
  endtask

  // Monitor: count busy cycles and check each completion against the scoreboard.
  initial begin : monitor
    int   bcnt;
    exp_t e;
    bcnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_done: got done=1 expected no pending operation at %0t", $time);
        end else begin
          e = sb.pop_front();
          chk("sb_q", 32'(q), 32'(e.q));
          chk("sb_ser", 32'(ser_out), 32'(e.ser));
          chk("sb_busy_cycles", 32'(bcnt), 32'(e.steps));
        end
        bcnt = 0;
      end else if (busy === 1'b1) begin
        bcnt++;
      end else begin
        bcnt = 0;
      end
    end
  end

  // Stimulus: directed cases from the plan, then randomized operations.
  initial begin : stim
    logic [7:0] v;
    reset = 1'b1; load = 1'b0; load_val = 8'h00; start = 1'b0;
    dir = 1'b0; mode = 2'b00; amount = 4'd0;
`ifdef SHIFT_ENGINE_ABORT_EN
    abort = 1'b0;
`endif
    m_q = 8'h00; m_ser = 1'b0;
    tick(); tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ser", 32'(ser_out), 32'd0);

    // Arithmetic right by 3, stepped.
    do_load(8'b1001_0110);
    issue_start(1'b0, 2'b01, 4'd3, 1'b1);
    chk("asr_busy_e0", 32'(busy), 32'd1);
    chk("asr_q_e0", 32'(q), 32'h96);
    tick(); chk("asr_q_e1", 32'(q), 32'hCB);
    tick(); chk("asr_q_e2", 32'(q), 32'hE5);
    tick(); chk("asr_q_e3", 32'(q), 32'hF2);
    chk("asr_ser", 32'(ser_out), 32'd1);
    chk("asr_done", 32'(done), 32'd1);
    chk("asr_busy_end", 32'(busy), 32'd0);
    tick();
    chk("asr_done_pulse", 32'(done), 32'd0);

    // Rotate left by 9 (more than WIDTH).
    do_load(8'h81);
    issue_start(1'b1, 2'b10, 4'd9, 1'b1);
    wait_done(1'b0);
    chk("rol9_q", 32'(q), 32'h03);
    chk("rol9_ser", 32'(ser_out), 32'd1);

    // Zero amount completes immediately.
    do_load(8'h5A);
    issue_start(1'b0, 2'b00, 4'd0, 1'b1);
    chk("amt0_done", 32'(done), 32'd1);
    chk("amt0_busy", 32'(busy), 32'd0);
    chk("amt0_q", 32'(q), 32'h5A);
    wait_done(1'b0);

    // Load ignored mid-shift, then reset aborts without done.
    do_load(8'hFF);
    issue_start(1'b1, 2'b00, 4'd4, 1'b0);
    tick();
    load = 1'b1; load_val = 8'h00;
    tick();
    load = 1'b0;
    chk("shift_ignores_load", 32'(q), 32'hFC);
    chk("shift_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_q", 32'(q), 32'h00);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_ser", 32'(ser_out), 32'd0);
    m_q = 8'h00; m_ser = 1'b0;
    repeat (3) tick();
    chk("midrst_no_done", 32'(done), 32'd0);

`ifdef SHIFT_ENGINE_ABORT_EN
    // Abort after two logical right steps keeps the partial result.
    do_load(8'h80);
    issue_start(1'b0, 2'b00, 4'd6, 1'b0);
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_q", 32'(q), 32'h20);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    m_q = 8'h20; m_ser = 1'b0;
    tick();
    chk("abort_no_done", 32'(done), 32'd0);
    do_load(8'h33);
    chk("abort_then_load", 32'(q), 32'h33);
`endif

    // Randomized operations with noise on inputs while busy.
    for (int i = 0; i < 30; i++) begin
      v = 8'($urandom);
      if ($urandom_range(3) == 0) begin
        load = 1'b1; start = 1'b1; load_val = v;
        tick();
        load = 1'b0; start = 1'b0;
        m_q = v;
        chk("load_beats_start_q", 32'(q), 32'(v));
        chk("load_beats_start_busy", 32'(busy), 32'd0);
      end else if ($urandom_range(1) == 0) begin
        do_load(v);
      end
      issue_start(1'($urandom_range(1)), 2'($urandom_range(3)), 4'($urandom_range(15)), 1'b1);
      wait_done(1'b1);
    end

    repeat (3) tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
